spgd_seq_ctrl: RTL

SPGD_SEQ_CTRL -- requirements
Module: spgd_seq_ctrl

---
 rtl/spgd_seq_ctrl.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/spgd_seq_ctrl.sv
// ---------------------------------------------------------------------------
// spgd_seq_ctrl
//
// Sequencer for one SPGD (stochastic parallel gradient descent) iteration.
// Each trigger runs the sequence below. The dither DAC is driven with U+dU
// and then with U-dU. After each settle/acquire window the cost metric is
// captured as J+ and then J-. After both captures the update unit is strobed,
// and the sequencer waits for its acknowledge.
//
//   IDLE -> TRIG_WAIT -> SETTLE_A -> ACQ_A -> JP_WR -> SETTLE_B -> ACQ_B
//        -> JM_WR -> U_WR -> U_WAIT -> (TRIG_WAIT | DONE -> IDLE)
//
// Parameters
//   CNT_W   width of the settle / acquire cycle-count inputs
//   ITER_W  width of the iteration target and iteration counter
//
// Ports
//   adc_clk        sole clock, rising edge
//   adc_rstn       asynchronous active-low reset
//   start          level-sensitive run enable; low forces IDLE
//   trig_in        iteration trigger (rising edge detected internally)
//   settle_cycles  DAC settle length minus 1 (latched per iteration)
//   acq_cycles     ADC acquire length minus 1 (latched per iteration)
//   n_iter         iteration target, 0 = free-run
//   u_done         update unit acknowledge (only honoured in U_WAIT)
//   jp_wrt         J+ capture strobe
//   jm_wrt         J- capture strobe
//   u_wrt          control-vector update strobe
//   dac_sel        DAC source: 00 off, 01 U+dU, 10 U-dU, 11 U
//   busy           high in every state except IDLE
//   done           one-cycle completion pulse
//   iter_cnt       completed iterations (wraps)
//   trig_miss      saturating count of triggers ignored mid-sequence
//   state          current state code, for debug
// ---------------------------------------------------------------------------
module spgd_seq_ctrl #(
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned ITER_W = 16
) (
  input  logic              adc_clk,
  input  logic              adc_rstn,
  input  logic              start,
  input  logic              trig_in,
  input  logic [CNT_W-1:0]  settle_cycles,
  input  logic [CNT_W-1:0]  acq_cycles,
  input  logic [ITER_W-1:0] n_iter,
  input  logic              u_done,
  output logic              jp_wrt,
  output logic              jm_wrt,
  output logic              u_wrt,
  output logic [1:0]        dac_sel,
  output logic              busy,
  output logic              done,
  output logic [ITER_W-1:0] iter_cnt,
  output logic [7:0]        trig_miss,
  output logic [3:0]        state
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_TRIG_WAIT = 4'd1,
    S_SETTLE_A  = 4'd2,
    S_ACQ_A     = 4'd3,
    S_JP_WR     = 4'd4,
    S_SETTLE_B  = 4'd5,
    S_ACQ_B     = 4'd6,
    S_JM_WR     = 4'd7,
    S_U_WR      = 4'd8,
    S_U_WAIT    = 4'd9,
    S_DONE      = 4'd10
  } state_e;

  localparam logic [ITER_W-1:0] ITER_ONE = {{(ITER_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [7:0]        MISS_MAX = 8'hFF;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  phase_cnt_q, phase_cnt_d;
  logic [CNT_W-1:0]  settle_lat_q, settle_lat_d;
  logic [CNT_W-1:0]  acq_lat_q, acq_lat_d;
  logic [ITER_W-1:0] iter_cnt_q, iter_cnt_d;
  logic [7:0]        trig_miss_q, trig_miss_d;
  logic              trig_prev_q, trig_prev_d;
  // Set on leaving DONE so a start that is still high cannot relaunch a
  // run; cleared once start has been seen low.
  logic              run_lock_q, run_lock_d;

  logic              trig_rise;
  logic [ITER_W-1:0] iter_inc;

  assign trig_rise = trig_in & ~trig_prev_q;
  assign iter_inc  = iter_cnt_q + ITER_ONE;

  // -------------------------------------------------------------------------
  // Next-state and datapath update
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d      = state_q;
    phase_cnt_d  = '0;
    settle_lat_d = settle_lat_q;
    acq_lat_d    = acq_lat_q;
    iter_cnt_d   = iter_cnt_q;
    trig_miss_d  = trig_miss_q;
    run_lock_d   = run_lock_q;
    trig_prev_d  = trig_in;

    // Triggers arriving mid-sequence are counted and otherwise dropped.
    if (trig_rise && (state_q != S_IDLE) && (state_q != S_TRIG_WAIT) &&
        (trig_miss_q != MISS_MAX)) begin
      trig_miss_d = trig_miss_q + 8'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (start && !run_lock_q) begin
          state_d     = S_TRIG_WAIT;
          iter_cnt_d  = '0;
          trig_miss_d = '0;
        end
      end
      S_TRIG_WAIT: begin
        if (trig_rise) begin
          state_d      = S_SETTLE_A;
          settle_lat_d = settle_cycles;
          acq_lat_d    = acq_cycles;
        end
      end
      // Timed phases: phase_cnt runs 0..limit, so a phase lasts limit+1
      // cycles and restarts from 0 on every state change.
      S_SETTLE_A: begin
        if (phase_cnt_q == settle_lat_q) state_d = S_ACQ_A;
        else phase_cnt_d = phase_cnt_q + CNT_ONE;
      end
      S_ACQ_A: begin
        if (phase_cnt_q == acq_lat_q) state_d = S_JP_WR;
        else phase_cnt_d = phase_cnt_q + CNT_ONE;
      end
      S_JP_WR: state_d = S_SETTLE_B;
      S_SETTLE_B: begin
        if (phase_cnt_q == settle_lat_q) state_d = S_ACQ_B;
        else phase_cnt_d = phase_cnt_q + CNT_ONE;
      end
      S_ACQ_B: begin
        if (phase_cnt_q == acq_lat_q) state_d = S_JM_WR;
        else phase_cnt_d = phase_cnt_q + CNT_ONE;
      end
      S_JM_WR: state_d = S_U_WR;
      S_U_WR:  state_d = S_U_WAIT;
      S_U_WAIT: begin
        if (u_done) begin
          iter_cnt_d = iter_inc;
          if ((n_iter != '0) && (iter_inc == n_iter)) state_d = S_DONE;
          else state_d = S_TRIG_WAIT;
        end
      end
      S_DONE: begin
        state_d    = S_IDLE;
        run_lock_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Dropping start aborts from anywhere; the counters are frozen so the
    // abort point stays visible until the next run clears them.
    if (!start) begin
      state_d     = S_IDLE;
      phase_cnt_d = '0;
      iter_cnt_d  = iter_cnt_q;
      trig_miss_d = trig_miss_q;
      run_lock_d  = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  // NOTE: non-blocking assignments here so every flop samples the values
  // from before the edge, independent of statement order.
  always_ff @(posedge adc_clk or negedge adc_rstn) begin
    if (!adc_rstn) begin
      state_q      <= S_IDLE;
      phase_cnt_q  <= '0;
      settle_lat_q <= '0;
      acq_lat_q    <= '0;
      iter_cnt_q   <= '0;
      trig_miss_q  <= '0;
      trig_prev_q  <= 1'b0;
      run_lock_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_cnt_q  <= phase_cnt_d;
      settle_lat_q <= settle_lat_d;
      acq_lat_q    <= acq_lat_d;
      iter_cnt_q   <= iter_cnt_d;
      trig_miss_q  <= trig_miss_d;
      trig_prev_q  <= trig_prev_d;
      run_lock_q   <= run_lock_d;
    end
  end

  // -------------------------------------------------------------------------
  // Moore output decode (state register only)
  // -------------------------------------------------------------------------
  always_comb begin
    jp_wrt  = 1'b0;
    jm_wrt  = 1'b0;
    u_wrt   = 1'b0;
    dac_sel = 2'b00;
    done    = 1'b0;
    case (state_q)
      S_TRIG_WAIT: dac_sel = 2'b11;
      S_SETTLE_A:  dac_sel = 2'b01;
      S_ACQ_A:     dac_sel = 2'b01;
      S_JP_WR: begin
        dac_sel = 2'b01;
        jp_wrt  = 1'b1;
      end
      S_SETTLE_B:  dac_sel = 2'b10;
      S_ACQ_B:     dac_sel = 2'b10;
      S_JM_WR: begin
        dac_sel = 2'b10;
        jm_wrt  = 1'b1;
      end
      S_U_WR: begin
        dac_sel = 2'b11;
        u_wrt   = 1'b1;
      end
      S_U_WAIT:    dac_sel = 2'b11;
      S_DONE: begin
        dac_sel = 2'b11;
        done    = 1'b1;
      end
      default:     dac_sel = 2'b00;
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign iter_cnt  = iter_cnt_q;
  assign trig_miss = trig_miss_q;
  assign state     = state_q;

endmodule
